// File: rtl/vc_demux.sv
// vc_demux: pops the Main FIFO and steers each word to VC0 or VC1 by its class (MSB) bit,
// with almost-full backpressure, saturating per-VC counters and an INIT/IDLE/ACTIVE/ERROR FSM.
module vc_demux #(
    parameter int BW    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             main_empty,
    input  logic [BW-1:0]    main_data_out,
    input  logic             main_error,
    output logic             main_rd,
    input  logic             vc0_almost_full,
    input  logic             vc1_almost_full,
    input  logic             vc0_error,
    input  logic             vc1_error,
    output logic             vc0_wr,
    output logic             vc1_wr,
    output logic [BW-1:0]    vc_data,
    output logic [CNT_W-1:0] vc0_count,
    output logic [CNT_W-1:0] vc1_count,
    output logic [1:0]       state,
    output logic             idle,
    output logic             error_out
);
    typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2, ERROR = 2'd3} state_t;

    state_t           state_q, state_d;
    logic             pend_q, vc0_wr_q, vc1_wr_q, idle_q, error_q;
    logic [BW-1:0]    vc_data_q;
    logic [CNT_W-1:0] vc0_count_q, vc1_count_q;
    logic             err_any, active, wr_ok, vc0_wr_d, vc1_wr_d;

    assign err_any  = main_error | vc0_error | vc1_error;
    assign active   = state_q == ACTIVE;
    // A pop in a cycle that is leaving ACTIVE would only be dropped, so it is withheld.
    assign main_rd  = active & ~init & ~err_any & ~main_empty & ~vc0_almost_full & ~vc1_almost_full;
    assign wr_ok    = pend_q & active & ~init & ~err_any;
    assign vc0_wr_d = wr_ok & ~main_data_out[BW-1];
    assign vc1_wr_d = wr_ok & main_data_out[BW-1];

    always_comb begin
        state_d = init                                  ? INIT   :
                  err_any                               ? ERROR  :
                  state_q == INIT                       ? IDLE   :
                  (state_q == IDLE && !main_empty)      ? ACTIVE :
                  (active && main_empty && !pend_q)     ? IDLE   :
                                                          state_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            pend_q      <= 1'b0;
            vc0_wr_q    <= 1'b0;
            vc1_wr_q    <= 1'b0;
            vc_data_q   <= '0;
            vc0_count_q <= '0;
            vc1_count_q <= '0;
            idle_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= main_rd;
            vc0_wr_q    <= vc0_wr_d;
            vc1_wr_q    <= vc1_wr_d;
            if (wr_ok) vc_data_q <= main_data_out;
            idle_q      <= state_d == IDLE;
            error_q     <= state_d == ERROR;
            vc0_count_q <= (init || state_q == INIT) ? '0 : vc0_count_q + CNT_W'(vc0_wr_d & ~&vc0_count_q);
            vc1_count_q <= (init || state_q == INIT) ? '0 : vc1_count_q + CNT_W'(vc1_wr_d & ~&vc1_count_q);
        end
    end

    assign vc0_wr    = vc0_wr_q;
    assign vc1_wr    = vc1_wr_q;
    assign vc_data   = vc_data_q;
    assign vc0_count = vc0_count_q;
    assign vc1_count = vc1_count_q;
    assign state     = state_q;
    assign idle      = idle_q;
    assign error_out = error_q;
endmodule

// File: tb/tb_vc_demux.sv
// tb_vc_demux: scoreboard bench for vc_demux with a behavioural Main FIFO and a CNT_W=2 twin
// instance for counter saturation.
`timescale 1ns/1ps
module tb_vc_demux;
    logic       clk = 1'b0;
    logic       reset = 1'b1, init = 1'b0, main_error = 1'b0;
    logic       vc0_almost_full = 1'b0, vc1_almost_full = 1'b0, vc0_error = 1'b0, vc1_error = 1'b0;
    logic       main_empty = 1'b1;
    logic [5:0] main_data_out = '0;
    logic       main_rd, vc0_wr, vc1_wr, idle, error_out;
    logic [5:0] vc_data;
    logic [7:0] vc0_count, vc1_count;
    logic [1:0] state;
    logic       d2_rd, d2_wr0, d2_wr1, d2_idle, d2_err;
    logic [5:0] d2_data;
    logic [1:0] d2_c0, d2_c1, d2_state;
    logic       push_req = 1'b0;
    logic [5:0] push_val = '0;
    logic [5:0] mq[$];
    logic [5:0] exp_q[$];
    int         pass_n = 0, total_n = 0;

    always #5 clk = ~clk;

    vc_demux #(.BW(6), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .init(init), .main_empty(main_empty),
        .main_data_out(main_data_out), .main_error(main_error), .main_rd(main_rd),
        .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
        .vc0_error(vc0_error), .vc1_error(vc1_error), .vc0_wr(vc0_wr), .vc1_wr(vc1_wr),
        .vc_data(vc_data), .vc0_count(vc0_count), .vc1_count(vc1_count),
        .state(state), .idle(idle), .error_out(error_out)
    );

    vc_demux #(.BW(6), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .init(init), .main_empty(main_empty),
        .main_data_out(main_data_out), .main_error(main_error), .main_rd(d2_rd),
        .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
        .vc0_error(vc0_error), .vc1_error(vc1_error), .vc0_wr(d2_wr0), .vc1_wr(d2_wr1),
        .vc_data(d2_data), .vc0_count(d2_c0), .vc1_count(d2_c1),
        .state(d2_state), .idle(d2_idle), .error_out(d2_err)
    );

    // Main FIFO model: read data appears the cycle after main_rd is sampled.
    always @(posedge clk) begin
        if (reset) mq.delete();
        else begin
            if (main_rd && mq.size() != 0) main_data_out <= mq.pop_front();
            if (push_req) mq.push_back(push_val);
        end
        main_empty <= mq.size() == 0;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push_req = 1'b0; init = 1'b0; main_error = 1'b0;
        vc0_almost_full = 1'b0; vc1_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total_n++;
        if ({main_rd, vc0_wr, vc1_wr, idle, error_out} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000", {main_rd, vc0_wr, vc1_wr, idle, error_out});
        else pass_n++;
        total_n++;
        if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_n++;
        total_n++;
        if ({vc_data, vc0_count, vc1_count} !== 22'd0)
            $display("FAIL reset_regs: got data=%h c0=%0d c1=%0d want 0", vc_data, vc0_count, vc1_count);
        else pass_n++;
        reset = 1'b0;
        @(negedge clk);
        total_n++;
        if ({state, idle} !== 3'b011) $display("FAIL init_to_idle: got state=%0d idle=%b want 1/1", state, idle);
        else pass_n++;
    endtask

    task automatic test_idle_empty();
        int bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (main_rd || vc0_wr || vc1_wr) bad++;
        end
        total_n++;
        if (bad !== 0) $display("FAIL idle_no_activity: got %0d active cycles want 0", bad); else pass_n++;
        total_n++;
        if ({state, idle} !== 3'b011) $display("FAIL idle_state: got state=%0d idle=%b want 1/1", state, idle);
        else pass_n++;
    endtask

    task automatic test_basic();
        logic [5:0] words [3];
        logic [5:0] e;
        int first_rd = -1, last_rd = -1, first_wr = -1, rd_n = 0;
        words = '{6'h05, 6'h21, 6'h3A};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (main_rd) begin
                rd_n++;
                last_rd = c;
                if (first_rd < 0) first_rd = c;
            end
            if (vc0_wr || vc1_wr) begin
                if (first_wr < 0) first_wr = c;
                total_n++;
                if (exp_q.size() == 0) $display("FAIL basic_extra_write: got data=%h want no write", vc_data);
                else begin
                    e = exp_q.pop_front();
                    if ({vc1_wr, vc0_wr, vc_data} !== {e[5], ~e[5], e})
                        $display("FAIL basic_route: got wr1=%b wr0=%b data=%h want wr1=%b wr0=%b data=%h",
                                 vc1_wr, vc0_wr, vc_data, e[5], ~e[5], e);
                    else pass_n++;
                end
            end
            push_req = c < 3;
            if (c < 3) begin
                push_val = words[c];
                exp_q.push_back(words[c]);
            end
        end
        total_n++;
        if (rd_n !== 3 || last_rd - first_rd !== 2)
            $display("FAIL basic_pop_run: got %0d pops over %0d cycles want 3 consecutive", rd_n, last_rd - first_rd + 1);
        else pass_n++;
        total_n++;
        if (first_wr - first_rd !== 2) $display("FAIL basic_latency: got %0d want 2", first_wr - first_rd);
        else pass_n++;
        total_n++;
        if ({vc0_count, vc1_count} !== {8'd1, 8'd2})
            $display("FAIL basic_counts: got c0=%0d c1=%0d want 1/2", vc0_count, vc1_count);
        else pass_n++;
        total_n++;
        if (exp_q.size() != 0 || state !== 2'd1)
            $display("FAIL basic_drain: got %0d missing, state=%0d want 0 missing, state=1", exp_q.size(), state);
        else pass_n++;
    endtask

    task automatic test_error();
        int bad = 0;
        @(negedge clk);
        push_req = 1'b1; push_val = 6'h11;
        @(negedge clk);
        push_val = 6'h2A;
        @(negedge clk);
        push_req = 1'b0;
        @(negedge clk);
        main_error = 1'b1;
        @(negedge clk);
        total_n++;
        if ({state, error_out, vc0_wr, vc1_wr, main_rd} !== 6'b11_1_000)
            $display("FAIL error_entry: got state=%0d err=%b wr0=%b wr1=%b rd=%b want 3/1/0/0/0",
                     state, error_out, vc0_wr, vc1_wr, main_rd);
        else pass_n++;
        main_error = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (main_rd || vc0_wr || vc1_wr || state !== 2'd3) bad++;
        end
        total_n++;
        if (bad !== 0) $display("FAIL error_hold: got %0d bad cycles want 0", bad); else pass_n++;
        init = 1'b1;
        @(negedge clk);
        total_n++;
        if ({state, vc0_count, vc1_count, idle, error_out} !== 20'd0)
            $display("FAIL error_init: got state=%0d c0=%0d c1=%0d idle=%b err=%b want all 0",
                     state, vc0_count, vc1_count, idle, error_out);
        else pass_n++;
        init = 1'b0;
        @(negedge clk);
        total_n++;
        if ({state, idle, error_out} !== 4'b01_1_0)
            $display("FAIL error_recover: got state=%0d idle=%b err=%b want 1/1/0", state, idle, error_out);
        else pass_n++;
    endtask

    task automatic test_backpressure();
        logic [5:0] e, w;
        int wr_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vc1_almost_full) begin
                total_n++;
                if (main_rd !== 1'b0) $display("FAIL bp_hold: got main_rd=%b want 0 at cycle %0d", main_rd, c);
                else pass_n++;
            end
            if (c == 10) begin
                total_n++;
                if (main_rd !== 1'b1) $display("FAIL bp_resume: got main_rd=%b want 1", main_rd); else pass_n++;
            end
            if (vc0_wr || vc1_wr) begin
                wr_n++;
                total_n++;
                if (exp_q.size() == 0) $display("FAIL bp_extra_write: got data=%h want no write", vc_data);
                else begin
                    e = exp_q.pop_front();
                    if ({vc1_wr, vc0_wr, vc_data} !== {e[5], ~e[5], e})
                        $display("FAIL bp_route: got wr1=%b wr0=%b data=%h want wr1=%b wr0=%b data=%h",
                                 vc1_wr, vc0_wr, vc_data, e[5], ~e[5], e);
                    else pass_n++;
                end
            end
            w = 6'($urandom_range(0, 63));
            push_req = c < 12;
            push_val = w;
            if (c < 12) exp_q.push_back(w);
            vc1_almost_full = c >= 5 && c < 9;
        end
        total_n++;
        if (wr_n !== 12 || exp_q.size() != 0)
            $display("FAIL bp_no_loss: got %0d writes, %0d missing want 12/0", wr_n, exp_q.size());
        else pass_n++;
    endtask

    task automatic test_saturate();
        logic [5:0] e, w;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (vc0_wr || vc1_wr) begin
                total_n++;
                if (exp_q.size() == 0) $display("FAIL sat_extra_write: got data=%h want no write", vc_data);
                else begin
                    e = exp_q.pop_front();
                    if ({vc1_wr, vc0_wr, vc_data} !== {1'b0, 1'b1, e})
                        $display("FAIL sat_route: got wr1=%b wr0=%b data=%h want 0/1/%h", vc1_wr, vc0_wr, vc_data, e);
                    else pass_n++;
                end
            end
            w = 6'($urandom_range(0, 31));
            push_req = c < 5;
            push_val = w;
            if (c < 5) exp_q.push_back(w);
        end
        total_n++;
        if ({d2_c0, d2_c1} !== {2'd3, 2'd0}) $display("FAIL sat_count2: got c0=%0d c1=%0d want 3/0", d2_c0, d2_c1);
        else pass_n++;
        total_n++;
        if (vc0_count !== 8'd5) $display("FAIL sat_count8: got %0d want 5", vc0_count); else pass_n++;
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            push_req = 1'b1;
            push_val = 6'($urandom_range(0, 63));
        end
        reset = 1'b1;
        push_req = 1'b0;
        @(negedge clk);
        total_n++;
        if ({main_rd, vc0_wr, vc1_wr, vc_data, vc0_count, vc1_count, state, idle, error_out} !== 29'd0)
            $display("FAIL midreset_outputs: got rd=%b wr0=%b wr1=%b data=%h c0=%0d c1=%0d state=%0d want all 0",
                     main_rd, vc0_wr, vc1_wr, vc_data, vc0_count, vc1_count, state);
        else pass_n++;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (vc0_wr || vc1_wr || main_rd) bad++;
        end
        total_n++;
        if (bad !== 0 || state !== 2'd1)
            $display("FAIL midreset_quiet: got %0d bad cycles state=%0d want 0/1", bad, state);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_idle_empty();
        test_basic();
        test_error();
        do_reset();
        test_backpressure();
        do_reset();
        test_saturate();
        do_reset();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
